// File: rtl/aluctl_defs_pkg.sv
// Shared ALU control encodings: control words, ALUOp classes, funct and opcode values.
// Used by the ALU control issuer, the ALU and the main control unit.
package aluctl_defs;

  localparam int NB_ALUCTL_DEF = 4;

  localparam logic [3:0] CTL_AND     = 4'b0000;
  localparam logic [3:0] CTL_OR      = 4'b0001;
  localparam logic [3:0] CTL_ADD     = 4'b0010;
  localparam logic [3:0] CTL_SUB     = 4'b0110;
  localparam logic [3:0] CTL_SLT     = 4'b0111;
  localparam logic [3:0] CTL_NOR     = 4'b1100;
  localparam logic [3:0] CTL_XOR     = 4'b1101;
  localparam logic [3:0] CTL_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_e;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

endpackage

// File: rtl/seg_execute_aluctl_dec.sv
// Combinational ALU control decode: ALUOp/opcode/funct to control word,
// zero-extend request and illegal flag.
module seg_execute_aluctl_dec
  import aluctl_defs::*;
#(
  parameter int LEN_OP    = 6,
  parameter int LEN_FUNCT = 6,
  parameter int NB_ALUOP  = 2,
  parameter int NB_ALUCTL = 4
) (
  input  logic [NB_ALUOP-1:0]  i_ALUOp,
  input  logic [LEN_OP-1:0]    i_opcode,
  input  logic [LEN_FUNCT-1:0] i_funct,
  output logic [NB_ALUCTL-1:0] o_ctl,
  output logic                 o_zero_ext,
  output logic                 o_illegal
);

  // Anything not explicitly recognised falls through to ILLEGAL.
  always_comb begin
    o_ctl      = CTL_ILLEGAL;
    o_zero_ext = 1'b0;
    case (i_ALUOp)
      ALUOP_MEM:    o_ctl = CTL_ADD;
      ALUOP_BRANCH: o_ctl = CTL_SUB;
      ALUOP_RTYPE: begin
        case (i_funct)
          FN_ADD, FN_ADDU: o_ctl = CTL_ADD;
          FN_SUB, FN_SUBU: o_ctl = CTL_SUB;
          FN_AND:          o_ctl = CTL_AND;
          FN_OR:           o_ctl = CTL_OR;
          FN_XOR:          o_ctl = CTL_XOR;
          FN_NOR:          o_ctl = CTL_NOR;
          FN_SLT:          o_ctl = CTL_SLT;
          default:         o_ctl = CTL_ILLEGAL;
        endcase
      end
      default: begin
        case (i_opcode)
          OP_ADDI, OP_ADDIU: o_ctl = CTL_ADD;
          OP_SLTI:           o_ctl = CTL_SLT;
          OP_ANDI: begin
            o_ctl      = CTL_AND;
            o_zero_ext = 1'b1;
          end
          OP_ORI: begin
            o_ctl      = CTL_OR;
            o_zero_ext = 1'b1;
          end
          OP_XORI: begin
            o_ctl      = CTL_XOR;
            o_zero_ext = 1'b1;
          end
          default:           o_ctl = CTL_ILLEGAL;
        endcase
      end
    endcase
  end

  assign o_illegal = (o_ctl == CTL_ILLEGAL);

endmodule

// File: rtl/seg_execute_aluctl.sv
// ID/EX ALU control register: registers the decoded control word with
// flush/stall handling and keeps a saturating count of illegal encodings.
module seg_execute_aluctl
  import aluctl_defs::*;
#(
  parameter int LEN_OP    = 6,
  parameter int LEN_FUNCT = 6,
  parameter int NB_ALUOP  = 2,
  parameter int NB_ALUCTL = 4,
  parameter int NB_ERRCNT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic [NB_ALUOP-1:0]  i_ALUOp,
  input  logic [LEN_OP-1:0]    i_opcode,
  input  logic [LEN_FUNCT-1:0] i_funct,
  output logic [NB_ALUCTL-1:0] o_ALUctl,
  output logic                 o_valid,
  output logic                 o_zero_ext,
  output logic                 o_illegal,
  output logic [NB_ERRCNT-1:0] o_illegal_count
);

  logic [NB_ALUCTL-1:0] w_ctl;
  logic                 w_zero_ext;
  logic                 w_illegal;

  logic [NB_ALUCTL-1:0] r_ctl;
  logic                 r_valid;
  logic                 r_zero_ext;
  logic                 r_illegal;
  logic [NB_ERRCNT-1:0] r_count;

  seg_execute_aluctl_dec #(
    .LEN_OP    (LEN_OP),
    .LEN_FUNCT (LEN_FUNCT),
    .NB_ALUOP  (NB_ALUOP),
    .NB_ALUCTL (NB_ALUCTL)
  ) u_dec (
    .i_ALUOp    (i_ALUOp),
    .i_opcode   (i_opcode),
    .i_funct    (i_funct),
    .o_ctl      (w_ctl),
    .o_zero_ext (w_zero_ext),
    .o_illegal  (w_illegal)
  );

  // Priority reset > flush > stall > load; an invalid load behaves as a bubble.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ctl      <= '0;
      r_valid    <= 1'b0;
      r_zero_ext <= 1'b0;
      r_illegal  <= 1'b0;
      r_count    <= '0;
    end else if (i_flush) begin
      r_ctl      <= '0;
      r_valid    <= 1'b0;
      r_zero_ext <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (!i_stall) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_ctl      <= w_ctl;
        r_zero_ext <= w_zero_ext;
        r_illegal  <= w_illegal;
        if (w_illegal && (r_count != '1)) begin
          r_count <= r_count + 1'b1;
        end
      end else begin
        r_ctl      <= '0;
        r_zero_ext <= 1'b0;
        r_illegal  <= 1'b0;
      end
    end
  end

  assign o_ALUctl        = r_ctl;
  assign o_valid         = r_valid;
  assign o_zero_ext      = r_zero_ext;
  assign o_illegal       = r_illegal;
  assign o_illegal_count = r_count;

endmodule

// File: doc/seg_execute_aluctl.md
# seg_execute_aluctl

ALU control issuer for the MIPS pipeline. It sits at the ID/EX boundary and decodes ALUOp, opcode and funct into the 4-bit ALU control word consumed by the execute-stage ALU. Results are registered, with stall/flush handling, so EX sees a stable control word for the whole cycle. It also raises a per-instruction illegal flag and keeps a saturating count of illegal encodings for debug.

## Interface
- LEN_OP, 6, opcode width
- LEN_FUNCT, 6, funct width
- NB_ALUOP, 2, ALUOp width
- NB_ALUCTL, 4, ALU control word width
- NB_ERRCNT, 8, illegal-count width

- i_clk  in  1  clock; all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  ID stage presents a valid instruction
- i_stall  in  1  hold EX register contents (hazard unit)
- i_flush  in  1  insert bubble (branch/jump squash)
- i_ALUOp  in  NB_ALUOP  00 mem-add, 01 branch-sub, 10 R-type, 11 I-type
- i_opcode  in  LEN_OP  instruction [31:26]
- i_funct  in  LEN_FUNCT  instruction [5:0]
- o_ALUctl  out  NB_ALUCTL  registered ALU control word
- o_valid  out  1  o_ALUctl belongs to a live instruction
- o_zero_ext  out  1  immediate must be zero-extended (andi/ori/xori)
- o_illegal  out  1  registered instruction had unsupported encoding
- o_illegal_count  out  NB_ERRCNT  saturating count of illegal instructions accepted

## Operation
- Control codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, XOR 1101, ILLEGAL 1111. The ALU yields 0 for 1111.
- ALUOp 00: ADD. ALUOp 01: SUB. Neither reads opcode or funct.
- ALUOp 10, funct map:
  - 100000/100001 → ADD
  - 100010/100011 → SUB
  - 100100 → AND, 100101 → OR, 100110 → XOR, 100111 → NOR
  - 101010 → SLT
  - anything else (including sltu 101011 and shifts) → ILLEGAL
- ALUOp 11, opcode map:
  - 001000/001001 → ADD
  - 001010 → SLT
  - 001100 → AND with zero_ext=1
  - 001101 → OR with zero_ext=1
  - 001110 → XOR with zero_ext=1
  - anything else (including lui 001111) → ILLEGAL
- o_illegal = 1 exactly when the decoded code is ILLEGAL.
- Register update priority per edge: reset > flush > stall > load.
  - reset: all outputs 0, counter 0.
  - flush: o_valid=0, o_ALUctl=0000, o_zero_ext=0, o_illegal=0. The counter holds.
  - stall: all registers hold, counter holds.
  - load: registers take the decode of the inputs. o_valid=i_valid. If i_valid=0, the decoded fields are forced to bubble values (as for flush).
- Counter increments only on a load with i_valid=1 and an illegal decode. It saturates at 2^NB_ERRCNT-1 and never wraps.

## Timing
- Latency: 1 cycle from inputs to o_* on a load edge.
- Decode is combinational. Only registered values drive outputs.
- Reset values: o_ALUctl 0000, o_valid 0, o_zero_ext 0, o_illegal 0, o_illegal_count 0.
- Stall held N cycles: outputs are constant for N cycles, and the instruction is counted once.
- Flush and stall in the same cycle: flush wins, giving a bubble the next cycle.
- Reset asserted mid-stall: outputs go to reset values on that edge, and the stall is ignored.

## Structure
- Shared package/header `aluctl_defs`: ALU control codes, ALUOp codes, funct and opcode constants. Also included by the ALU and the main control unit.
- Sub-module `seg_execute_aluctl_dec`: purely combinational decode producing ctl, zero_ext and illegal. The top holds the registers and the counter.

## Test plan
- Reset: assert i_reset with i_valid=1, ALUOp=10, funct=100000 → after that edge all outputs 0. Release, then one load → o_ALUctl=0010, o_valid=1.
- Full funct sweep, ALUOp=10: 100100→0000, 100101→0001, 100110→1101, 100111→1100, 101010→0111, 101011→1111 with o_illegal=1.
- I-type: opcode 001100 → 0000 with o_zero_ext=1; 001010 → 0111 with o_zero_ext=0; 001111 → 1111 with o_illegal=1.
- Stall: load 100010 (SUB), hold i_stall for 3 cycles while the inputs change → o_ALUctl stays 0110 and the counter is unchanged.
- Flush and stall together: valid SUB held, then flush=stall=1 → next cycle o_valid=0, o_ALUctl=0000.
- Counter saturation: 260 consecutive valid illegal loads → o_illegal_count reaches 255 and stays 255. A flush does not change it.
